// File: rtl/bus_arbiter_8way_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
// The master modport is the requester side. The slave modport is the arbiter side.
interface bus_arbiter_8way_if #(
  parameter int N = 8
);
  logic [N-1:0]         req;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] grant_id;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req,
    input  grant, grant_id, busy, timeout_err
  );

  modport slave (
    input  req,
    output grant, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter_8way.sv
// Round-robin arbiter for one shared datapath port. Grants are registered and one-hot.
// A dead RECOVER cycle separates owners. A hold watchdog revokes the grant from a stuck owner.
module bus_arbiter_8way #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter_8way_if.slave bus
);
  localparam int W  = $clog2(N);
  localparam int HW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RECOVER} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]   block_q, block_d, block_set;
  logic [N-1:0]   grant_q, grant_d;
  logic [W-1:0]   grant_id_q, grant_id_d;
  logic           terr_q, terr_d;

  logic [N-1:0]   elig;
  logic           found;
  logic [W-1:0]   win, idx, next_ptr;

  // A requester that was timed out stays masked until it drops req.
  assign elig = bus.req & ~block_q;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr_q) + k) % N);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign next_ptr = (grant_id_q == W'(N - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    terr_d     = 1'b0;
    block_set  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_GRANT;
          grant_d    = {{(N-1){1'b0}}, 1'b1} << win;
          grant_id_d = win;
          hold_cnt_d = '0;
        end
      end
      S_GRANT: begin
        // A release on the watchdog's final cycle counts as a normal release.
        if (!bus.req[grant_id_q]) begin
          state_d = S_RECOVER;
          grant_d = '0;
          ptr_d   = next_ptr;
        end else if (hold_cnt_q == HW'(TIMEOUT - 1)) begin
          state_d               = S_RECOVER;
          grant_d               = '0;
          ptr_d                 = next_ptr;
          terr_d                = 1'b1;
          block_set[grant_id_q] = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    block_d = (block_q & bus.req) | block_set;
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      block_q    <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      block_q    <= block_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      terr_q     <= terr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = |grant_q;
  assign bus.timeout_err = terr_q;
endmodule
